// File: rtl/dead_time_bridge.sv
// Complementary dead-time generator: one high/low gate pair per bridge leg,
// with separately latched dead intervals before each gate turn-on.
module dead_time_bridge #(
  parameter int N_CH     = 2,
  parameter int DT_WIDTH = 10
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [N_CH-1:0]     i_signal,
  input  logic [DT_WIDTH-1:0] i_dt_rise,
  input  logic [DT_WIDTH-1:0] i_dt_fall,
  output logic [N_CH-1:0]     o_high,
  output logic [N_CH-1:0]     o_low,
  output logic [N_CH-1:0]     o_dead
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_DT_RISE,
    ST_HIGH_ON,
    ST_DT_FALL,
    ST_LOW_ON
  } state_t;

  localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DT_WIDTH-1:0] dt_q, dt_d;
    logic [DT_WIDTH-1:0] eff_dt;
    logic                high_q, low_q, dead_q;

    // A programmed zero still yields one clock of dead time.
    assign eff_dt = (dt_q == '0) ? CNT_ONE : dt_q;

    // Next-state logic; every route to a gate passes through a full interval,
    // and a command reversal mid-interval restarts the opposite interval.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dt_d    = dt_q;
      if (!i_enable) begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_OFF: begin
            cnt_d = CNT_ONE;
            if (i_signal[ch]) begin
              state_d = ST_DT_RISE;
              dt_d    = i_dt_rise;
            end else begin
              state_d = ST_DT_FALL;
              dt_d    = i_dt_fall;
            end
          end
          ST_DT_RISE: begin
            if (!i_signal[ch]) begin
              state_d = ST_DT_FALL;
              dt_d    = i_dt_fall;
              cnt_d   = CNT_ONE;
            end else if (cnt_q >= eff_dt) begin
              state_d = ST_HIGH_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          ST_HIGH_ON: begin
            if (!i_signal[ch]) begin
              state_d = ST_DT_FALL;
              dt_d    = i_dt_fall;
              cnt_d   = CNT_ONE;
            end
          end
          ST_DT_FALL: begin
            if (i_signal[ch]) begin
              state_d = ST_DT_RISE;
              dt_d    = i_dt_rise;
              cnt_d   = CNT_ONE;
            end else if (cnt_q >= eff_dt) begin
              state_d = ST_LOW_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          ST_LOW_ON: begin
            if (i_signal[ch]) begin
              state_d = ST_DT_RISE;
              dt_d    = i_dt_rise;
              cnt_d   = CNT_ONE;
            end
          end
          default: begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Gate outputs are registered from the next state so they change on the
    // same edge as the state transition.
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        state_q <= ST_OFF;
        cnt_q   <= '0;
        dt_q    <= '0;
        high_q  <= 1'b0;
        low_q   <= 1'b0;
        dead_q  <= 1'b1;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        dt_q    <= dt_d;
        high_q  <= (state_d == ST_HIGH_ON);
        low_q   <= (state_d == ST_LOW_ON);
        dead_q  <= !((state_d == ST_HIGH_ON) || (state_d == ST_LOW_ON));
      end
    end

    assign o_high[ch] = high_q;
    assign o_low[ch]  = low_q;
    assign o_dead[ch] = dead_q;
  end

endmodule

// File: tb/tb_dead_time_bridge.sv
// Directed bench for dead_time_bridge: stimulus queues the expected output
// change events, a negedge monitor matches each observed change against them.
module tb_dead_time_bridge;

  logic       i_clock;
  logic       i_reset;
  logic       i_enable;
  logic [1:0] i_signal;
  logic [9:0] i_dt_rise;
  logic [9:0] i_dt_fall;
  logic [1:0] o_high;
  logic [1:0] o_low;
  logic [1:0] o_dead;

  dead_time_bridge #(.N_CH(2), .DT_WIDTH(10)) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_signal (i_signal),
    .i_dt_rise(i_dt_rise),
    .i_dt_fall(i_dt_fall),
    .o_high   (o_high),
    .o_low    (o_low),
    .o_dead   (o_dead)
  );

  typedef struct {
    int         cyc;
    logic [1:0] hi;
    logic [1:0] lo;
    logic [1:0] dd;
  } event_t;

  event_t     expQ[$];
  event_t     monEv;
  event_t     endEv;
  int         nCompared   = 0;
  int         nMismatched = 0;
  int         cyc         = 0;
  logic       monOn       = 1'b0;
  logic [5:0] prevOut;
  logic [5:0] curOut;
  int         e;
  int         t;

  assign curOut = {o_high, o_low, o_dead};

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Edge index: after posedge number n, cyc holds n.
  always @(posedge i_clock) cyc <= cyc + 1;

  // Every output change must match the next queued event in cycle and value;
  // the pair invariants are checked on every cycle.
  always @(negedge i_clock) begin
    if (monOn) begin
      nCompared++;
      if (((o_high & o_low) !== 2'b00) || (o_dead !== ~(o_high | o_low))) begin
        nMismatched++;
        $display("[TB] FAIL invariant at cycle %0d: high=%b low=%b dead=%b, required no overlap and dead=~(high|low)",
                 cyc, o_high, o_low, o_dead);
      end
      if (curOut !== prevOut) begin
        nCompared++;
        if (expQ.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL unexpected change at cycle %0d: high=%b low=%b dead=%b, required no change",
                   cyc, o_high, o_low, o_dead);
        end else begin
          monEv = expQ.pop_front();
          if ((monEv.cyc != cyc) || ({monEv.hi, monEv.lo, monEv.dd} !== curOut)) begin
            nMismatched++;
            $display("[TB] FAIL event: cycle %0d high=%b low=%b dead=%b, required cycle %0d high=%b low=%b dead=%b",
                     cyc, o_high, o_low, o_dead, monEv.cyc, monEv.hi, monEv.lo, monEv.dd);
          end
        end
      end
    end
    prevOut = curOut;
  end

  task automatic expectEvent(input int c, input logic [1:0] hi, input logic [1:0] lo);
    event_t ev;
    ev.cyc = c;
    ev.hi  = hi;
    ev.lo  = lo;
    ev.dd  = ~(hi | lo);
    expQ.push_back(ev);
  endtask

  // Drives inputs just after an edge; returns the edge that will sample them.
  task automatic applyStimulus(input logic rst, input logic en, input logic [1:0] sig,
                               input logic [9:0] dtr, input logic [9:0] dtf,
                               output int edgeIdx);
    i_reset   = rst;
    i_enable  = en;
    i_signal  = sig;
    i_dt_rise = dtr;
    i_dt_fall = dtf;
    edgeIdx   = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] hi,
                             input logic [1:0] lo, input logic [1:0] dd);
    nCompared++;
    if ({o_high, o_low, o_dead} !== {hi, lo, dd}) begin
      nMismatched++;
      $display("[TB] FAIL %s: high=%b low=%b dead=%b, required high=%b low=%b dead=%b",
               name, o_high, o_low, o_dead, hi, lo, dd);
    end
  endtask

  initial begin
    i_reset   = 1'b0;
    i_enable  = 1'b0;
    i_signal  = 2'b00;
    i_dt_rise = 10'd0;
    i_dt_fall = 10'd0;
    idle(1);

    // Reset state
    applyStimulus(1'b1, 1'b0, 2'b00, 10'd5, 10'd5, e);
    idle(2);
    checkOutput("reset", 2'b00, 2'b00, 2'b11);
    monOn = 1'b1;

    // Enable: ch0 high and ch1 low both after a 5-clock interval
    applyStimulus(1'b0, 1'b1, 2'b01, 10'd5, 10'd5, e);
    expectEvent(e + 5, 2'b01, 2'b10);
    idle(10);
    checkOutput("enable_settled", 2'b01, 2'b10, 2'b00);

    // Square wave on ch0, rise 3 / fall 7, two periods of 100 clocks
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b0, 1'b1, 2'b00, 10'd3, 10'd7, e);
      expectEvent(e, 2'b00, 2'b10);
      expectEvent(e + 7, 2'b00, 2'b11);
      idle(50);
      applyStimulus(1'b0, 1'b1, 2'b01, 10'd3, 10'd7, e);
      expectEvent(e, 2'b00, 2'b10);
      expectEvent(e + 3, 2'b01, 2'b10);
      idle(50);
    end

    // Zero dead time behaves as one clock, both channels swapping at once
    applyStimulus(1'b0, 1'b1, 2'b10, 10'd0, 10'd0, e);
    expectEvent(e, 2'b00, 2'b00);
    expectEvent(e + 1, 2'b10, 2'b01);
    idle(10);
    applyStimulus(1'b0, 1'b1, 2'b01, 10'd0, 10'd0, e);
    expectEvent(e, 2'b00, 2'b00);
    expectEvent(e + 1, 2'b01, 2'b10);
    idle(10);

    // Glitch: 4-clock high pulse from LOW_ON with 10-clock dead times
    applyStimulus(1'b0, 1'b1, 2'b00, 10'd10, 10'd10, e);
    expectEvent(e, 2'b00, 2'b10);
    expectEvent(e + 10, 2'b00, 2'b11);
    idle(15);
    applyStimulus(1'b0, 1'b1, 2'b01, 10'd10, 10'd10, e);
    expectEvent(e, 2'b00, 2'b10);
    idle(4);
    applyStimulus(1'b0, 1'b1, 2'b00, 10'd10, 10'd10, e);
    expectEvent(e + 10, 2'b00, 2'b11);
    idle(20);

    // Fall dead time changed mid-interval only affects the next interval
    applyStimulus(1'b0, 1'b1, 2'b01, 10'd2, 10'd4, e);
    expectEvent(e, 2'b00, 2'b10);
    expectEvent(e + 2, 2'b01, 2'b10);
    idle(5);
    applyStimulus(1'b0, 1'b1, 2'b00, 10'd2, 10'd4, e);
    expectEvent(e, 2'b00, 2'b10);
    expectEvent(e + 4, 2'b00, 2'b11);
    idle(2);
    applyStimulus(1'b0, 1'b1, 2'b00, 10'd2, 10'd20, e);
    idle(10);
    applyStimulus(1'b0, 1'b1, 2'b01, 10'd2, 10'd20, e);
    expectEvent(e, 2'b00, 2'b10);
    expectEvent(e + 2, 2'b01, 2'b10);
    idle(5);
    applyStimulus(1'b0, 1'b1, 2'b00, 10'd2, 10'd20, e);
    expectEvent(e, 2'b00, 2'b10);
    expectEvent(e + 20, 2'b00, 2'b11);
    idle(25);

    // Enable drop mid-DT_RISE, then reset (with enable held) during HIGH_ON
    applyStimulus(1'b0, 1'b1, 2'b01, 10'd5, 10'd5, e);
    expectEvent(e, 2'b00, 2'b10);
    idle(2);
    applyStimulus(1'b0, 1'b0, 2'b01, 10'd5, 10'd5, e);
    expectEvent(e, 2'b00, 2'b00);
    idle(3);
    checkOutput("disabled", 2'b00, 2'b00, 2'b11);
    applyStimulus(1'b0, 1'b1, 2'b01, 10'd5, 10'd5, e);
    expectEvent(e + 5, 2'b01, 2'b10);
    idle(8);
    applyStimulus(1'b1, 1'b1, 2'b01, 10'd5, 10'd5, e);
    expectEvent(e, 2'b00, 2'b00);
    idle(1);
    applyStimulus(1'b0, 1'b1, 2'b01, 10'd5, 10'd5, e);
    t = e;
    expectEvent(t + 5, 2'b01, 2'b10);
    idle(3);
    checkOutput("reenable_dead", 2'b00, 2'b00, 2'b11);
    idle(7);
    checkOutput("final", 2'b01, 2'b10, 2'b00);

    monOn = 1'b0;
    while (expQ.size() > 0) begin
      endEv = expQ.pop_front();
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL missing event: no change seen, required cycle %0d high=%b low=%b dead=%b",
               endEv.cyc, endEv.hi, endEv.lo, endEv.dd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
